// File: rtl/ipsa_ingress_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ipsa_ingress_arbiter_if
// AXI4-Stream bundle with LANES independent valid/ready/last lanes.
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface ipsa_ingress_arbiter_if #(
    parameter int LANES  = 1,
    parameter int DATA_W = 1024,
    parameter int KEEP_W = DATA_W / 8
);
    logic [LANES-1:0]        tvalid;
    logic [LANES-1:0]        tready;
    logic [LANES*DATA_W-1:0] tdata;
    logic [LANES*KEEP_W-1:0] tkeep;
    logic [LANES-1:0]        tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/ipsa_ingress_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ipsa_ingress_arbiter
// Packet-granular round-robin arbiter onto a single registered AXIS output.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module ipsa_ingress_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 1024,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int CNT_W     = 32
) (
    input  wire logic                    clock,
    input  wire logic                    reset,
    ipsa_ingress_arbiter_if.slave        s_axis,
    ipsa_ingress_arbiter_if.master       m_axis,
    output logic [NUM_PORTS-1:0]         grant,
    output logic [NUM_PORTS*CNT_W-1:0]   pkt_cnt
);
    localparam int                 c_IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [0:0]         c_ST_IDLE  = 1'b0;
    localparam logic [0:0]         c_ST_BUSY  = 1'b1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_PORTS - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_IDX_W-1:0] r_gidx;
    logic [c_IDX_W-1:0] w_gidx_nxt;
    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] w_rr_nxt;
    logic               w_any_valid;
    logic [c_IDX_W-1:0] w_pick;
    logic               w_slice_ready;
    logic               w_accept;
    logic               w_pkt_end;

    logic [DATA_W-1:0]  w_tdata [NUM_PORTS];
    logic [KEEP_W-1:0]  w_tkeep [NUM_PORTS];
    logic [CNT_W-1:0]   r_cnt   [NUM_PORTS];

    logic               r_m_tvalid;
    logic               r_m_tlast;
    logic [DATA_W-1:0]  r_m_tdata;
    logic [KEEP_W-1:0]  r_m_tkeep;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            assign w_tdata[p]                = s_axis.tdata[p*DATA_W +: DATA_W];
            assign w_tkeep[p]                = s_axis.tkeep[p*KEEP_W +: KEEP_W];
            assign pkt_cnt[p*CNT_W +: CNT_W] = r_cnt[p];
        end
    endgenerate

    function automatic logic [c_IDX_W-1:0] wrap_idx(input int v);
        return (v >= NUM_PORTS) ? c_IDX_W'(v - NUM_PORTS) : c_IDX_W'(v);
    endfunction

    // Scan downwards so the port closest to rr_ptr in rotation is written last.
    always_comb begin
        w_any_valid = 1'b0;
        w_pick      = r_rr_ptr;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (s_axis.tvalid[wrap_idx(int'(r_rr_ptr) + k)]) begin
                w_any_valid = 1'b1;
                w_pick      = wrap_idx(int'(r_rr_ptr) + k);
            end
        end
    end

    assign w_slice_ready = !r_m_tvalid || m_axis.tready[0];
    assign w_accept      = (r_state == c_ST_BUSY) && s_axis.tvalid[r_gidx] && w_slice_ready;
    assign w_pkt_end     = w_accept && s_axis.tlast[r_gidx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gidx   <= w_gidx_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any_valid) begin
                    w_state_nxt = c_ST_BUSY;
                    w_gidx_nxt  = w_pick;
                end
            end
            c_ST_BUSY: begin
                if (w_pkt_end) begin
                    w_state_nxt = c_ST_IDLE;
                    w_rr_nxt    = (r_gidx == c_LAST_IDX) ? '0 : r_gidx + c_IDX_W'(1);
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Ready is a function of state and slice occupancy only, never of tvalid.
    always_comb begin
        grant         = '0;
        s_axis.tready = '0;
        if (r_state == c_ST_BUSY) begin
            grant[r_gidx]         = 1'b1;
            s_axis.tready[r_gidx] = w_slice_ready;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= s_axis.tlast[r_gidx];
            r_m_tdata  <= w_tdata[r_gidx];
            r_m_tkeep  <= w_tkeep[r_gidx];
        end else if (m_axis.tready[0]) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_cnt[p] <= '0;
            end
        end else if (w_pkt_end) begin
            r_cnt[r_gidx] <= r_cnt[r_gidx] + CNT_W'(1);
        end
    end

    assign m_axis.tvalid = r_m_tvalid;
    assign m_axis.tlast  = r_m_tlast;
    assign m_axis.tdata  = r_m_tdata;
    assign m_axis.tkeep  = r_m_tkeep;

endmodule
`default_nettype wire

// File: tb/tb_ipsa_ingress_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_ipsa_ingress_arbiter
// Vector table, directed corner sequences and randomized traffic vs. a model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_ipsa_ingress_arbiter;
    localparam int NP     = 2;
    localparam int DW     = 64;
    localparam int KW     = 8;
    localparam int CW     = 8;
    localparam int QDEPTH = 1024;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ipsa_ingress_arbiter_if #(.LANES(NP), .DATA_W(DW), .KEEP_W(KW)) s_if ();
    ipsa_ingress_arbiter_if #(.LANES(1),  .DATA_W(DW), .KEEP_W(KW)) m_if ();
    logic [NP-1:0]    grant;
    logic [NP*CW-1:0] pkt_cnt;

    ipsa_ingress_arbiter #(
        .NUM_PORTS(NP), .DATA_W(DW), .KEEP_W(KW), .CNT_W(CW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .s_axis  (s_if),
        .m_axis  (m_if),
        .grant   (grant),
        .pkt_cnt (pkt_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic          rst_before;
        logic [NP-1:0] valid;
        logic [NP-1:0] last;
        logic [7:0]    tag0;
        logic [7:0]    tag1;
        logic          mr;
        logic [NP-1:0] e_grant;
        logic [NP-1:0] e_ready;
        logic          e_mv;
        logic          e_last;
        logic [7:0]    e_tag;
        int            e_c0;
        int            e_c1;
    } vec_t;

    int    n_pass  = 0;
    int    n_total = 0;
    int    seq     = 0;

    beat_t src_mem [NP][QDEPTH];
    int    src_head[NP];
    int    src_tail[NP];
    int    acc_cnt [NP];

    // Reference model: owner port (-1 when idle), rotation start, slice contents, counters
    int    m_owner;
    int    m_rr;
    bit    m_mv;
    beat_t m_slice;
    int    m_cnt[NP];
    int    delivered;
    bit    prev_stall;
    logic [DW-1:0] prev_data;

    vec_t  vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic rb, input logic [1:0] v, input logic [1:0] l,
                                input logic [7:0] t0, input logic [7:0] t1, input logic mr,
                                input logic [1:0] eg, input logic [1:0] er, input logic emv,
                                input logic el, input logic [7:0] et, input int c0, input int c1);
        vec_t r;
        r.rst_before = rb; r.valid = v; r.last = l; r.tag0 = t0; r.tag1 = t1; r.mr = mr;
        r.e_grant = eg; r.e_ready = er; r.e_mv = emv; r.e_last = el; r.e_tag = et;
        r.e_c0 = c0; r.e_c1 = c1;
        return r;
    endfunction

    task automatic clear_inputs();
        s_if.tvalid = '0;
        s_if.tlast  = '0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        m_if.tready = '0;
    endtask

    task automatic model_reset();
        m_owner    = -1;
        m_rr       = 0;
        m_mv       = 1'b0;
        m_slice    = '0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int p = 0; p < NP; p++) begin
            m_cnt[p]    = 0;
            src_head[p] = 0;
            src_tail[p] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic push_pkt(input int p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {8'(p), 24'(seq), 32'($urandom)};
            b.keep = 8'($urandom);
            b.last = (i == len - 1);
            src_mem[p][src_tail[p] % QDEPTH] = b;
            src_tail[p]++;
            seq++;
        end
    endtask

    function automatic bit pending();
        bit r;
        r = (m_owner >= 0) || m_mv;
        for (int p = 0; p < NP; p++) if (src_tail[p] > src_head[p]) r = 1'b1;
        return r;
    endfunction

    task automatic drive(input logic [NP-1:0] en, input logic mr);
        beat_t b;
        for (int p = 0; p < NP; p++) begin
            b = src_mem[p][src_head[p] % QDEPTH];
            s_if.tvalid[p]            = en[p] && (src_tail[p] > src_head[p]);
            s_if.tdata[p*DW +: DW]    = s_if.tvalid[p] ? b.data : '0;
            s_if.tkeep[p*KW +: KW]    = s_if.tvalid[p] ? b.keep : '0;
            s_if.tlast[p]             = s_if.tvalid[p] && b.last;
        end
        m_if.tready = mr;
    endtask

    // One cycle: drive sources, compare DUT against the model, then advance the model.
    task automatic step(input logic [NP-1:0] en, input logic mr);
        logic [NP-1:0] eg;
        logic [NP-1:0] er;
        bit            sr;
        beat_t         nb;
        int            o;
        @(negedge clock);
        drive(en, mr);
        #1;
        sr = !m_mv || mr;
        eg = '0;
        er = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            er[m_owner] = sr;
        end
        chk("grant", grant, eg);
        chk("s_tready", s_if.tready, er);
        chk("m_tvalid", m_if.tvalid, m_mv);
        if (m_mv) begin
            chk("m_tdata", m_if.tdata, m_slice.data);
            chk("m_tkeep", m_if.tkeep, m_slice.keep);
            chk("m_tlast", m_if.tlast, m_slice.last);
        end
        for (int p = 0; p < NP; p++) chk("pkt_cnt", pkt_cnt[p*CW +: CW], m_cnt[p]);
        if (m_if.tvalid[0] && !mr) chk("stall_ready", s_if.tready, '0);
        if (prev_stall) chk("stall_hold", m_if.tdata, prev_data);
        prev_stall = m_if.tvalid[0] && !mr;
        prev_data  = m_if.tdata;

        for (int p = 0; p < NP; p++) begin
            if (s_if.tvalid[p] && s_if.tready[p]) begin
                src_head[p]++;
                acc_cnt[p]++;
            end
        end

        if (m_mv && mr) delivered++;
        o = m_owner;
        if (o >= 0 && s_if.tvalid[o] && sr) begin
            nb.data = s_if.tdata[o*DW +: DW];
            nb.keep = s_if.tkeep[o*KW +: KW];
            nb.last = s_if.tlast[o];
            m_slice = nb;
            m_mv    = 1'b1;
            if (nb.last) begin
                m_cnt[o] = (m_cnt[o] + 1) % (1 << CW);
                m_rr     = (o + 1) % NP;
                m_owner  = -1;
            end
        end else begin
            if (mr) m_mv = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < NP; k++) begin
                    if (m_owner < 0 && s_if.tvalid[(m_rr + k) % NP]) m_owner = (m_rr + k) % NP;
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && pending(); c++) step('1, 1'b1);
        chk("drain_done", pending(), 0);
    endtask

    initial begin
        int base;
        for (int p = 0; p < NP; p++) acc_cnt[p] = 0;
        delivered = 0;
        clear_inputs();
        model_reset();

        // Single 3-beat packet on port 0, then 2-beat packets on both ports
        vecs[0]  = mk(1, 2'b01, 2'b00, 8'hA1, 8'h00, 1, 2'b00, 2'b00, 0, 0, 8'h00, 0, 0);
        vecs[1]  = mk(0, 2'b01, 2'b00, 8'hA1, 8'h00, 1, 2'b01, 2'b01, 0, 0, 8'h00, 0, 0);
        vecs[2]  = mk(0, 2'b01, 2'b00, 8'hA2, 8'h00, 1, 2'b01, 2'b01, 1, 0, 8'hA1, 0, 0);
        vecs[3]  = mk(0, 2'b01, 2'b01, 8'hA3, 8'h00, 1, 2'b01, 2'b01, 1, 0, 8'hA2, 0, 0);
        vecs[4]  = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 2'b00, 1, 1, 8'hA3, 1, 0);
        vecs[5]  = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 2'b00, 0, 0, 8'h00, 1, 0);
        vecs[6]  = mk(1, 2'b11, 2'b00, 8'hB1, 8'hC1, 1, 2'b00, 2'b00, 0, 0, 8'h00, 0, 0);
        vecs[7]  = mk(0, 2'b11, 2'b00, 8'hB1, 8'hC1, 1, 2'b01, 2'b01, 0, 0, 8'h00, 0, 0);
        vecs[8]  = mk(0, 2'b11, 2'b01, 8'hB2, 8'hC1, 1, 2'b01, 2'b01, 1, 0, 8'hB1, 0, 0);
        vecs[9]  = mk(0, 2'b10, 2'b00, 8'h00, 8'hC1, 1, 2'b00, 2'b00, 1, 1, 8'hB2, 1, 0);
        vecs[10] = mk(0, 2'b10, 2'b00, 8'h00, 8'hC1, 1, 2'b10, 2'b10, 0, 0, 8'h00, 1, 0);
        vecs[11] = mk(0, 2'b10, 2'b10, 8'h00, 8'hC2, 1, 2'b10, 2'b10, 1, 0, 8'hC1, 1, 0);
        vecs[12] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 2'b00, 1, 1, 8'hC2, 1, 1);
        vecs[13] = mk(0, 2'b11, 2'b11, 8'hD1, 8'hE1, 1, 2'b00, 2'b00, 0, 0, 8'h00, 1, 1);
        vecs[14] = mk(0, 2'b11, 2'b11, 8'hD1, 8'hE1, 1, 2'b01, 2'b01, 0, 0, 8'h00, 1, 1);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].rst_before) do_reset();
            @(negedge clock);
            s_if.tvalid = vecs[i].valid;
            s_if.tlast  = vecs[i].last;
            s_if.tdata  = {{8{vecs[i].tag1}}, {8{vecs[i].tag0}}};
            s_if.tkeep  = {vecs[i].tag1, vecs[i].tag0};
            m_if.tready = vecs[i].mr;
            #1;
            chk($sformatf("v%0d.grant", i), grant, vecs[i].e_grant);
            chk($sformatf("v%0d.s_tready", i), s_if.tready, vecs[i].e_ready);
            chk($sformatf("v%0d.m_tvalid", i), m_if.tvalid, vecs[i].e_mv);
            if (vecs[i].e_mv) begin
                chk($sformatf("v%0d.m_tdata", i), m_if.tdata, {8{vecs[i].e_tag}});
                chk($sformatf("v%0d.m_tkeep", i), m_if.tkeep, vecs[i].e_tag);
                chk($sformatf("v%0d.m_tlast", i), m_if.tlast, vecs[i].e_last);
            end
            chk($sformatf("v%0d.cnt0", i), pkt_cnt[CW-1:0], vecs[i].e_c0);
            chk($sformatf("v%0d.cnt1", i), pkt_cnt[2*CW-1:CW], vecs[i].e_c1);
        end

        // Downstream stall pattern 1,0,0,1 on a 4-beat port-1 packet
        do_reset();
        push_pkt(1, 4);
        delivered = 0;
        for (int c = 0; c < 40 && delivered < 4; c++) step(2'b11, (c % 4 == 0) || (c % 4 == 3));
        chk("stall_delivered", delivered, 4);
        chk("stall_cnt1", pkt_cnt[2*CW-1:CW], 1);

        // Port 0 pauses mid-packet while port 1 requests
        do_reset();
        push_pkt(0, 4);
        push_pkt(1, 2);
        base = acc_cnt[0];
        for (int c = 0; c < 10 && acc_cnt[0] - base < 2; c++) step(2'b11, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step(2'b10, 1'b1);
            chk("pause_p1_ready", s_if.tready[1], 0);
            chk("pause_grant", grant, 2'b01);
        end
        drain(40);
        chk("pause_cnt0", pkt_cnt[CW-1:0], 1);
        chk("pause_cnt1", pkt_cnt[2*CW-1:CW], 1);

        // Counter wrap on port 0
        do_reset();
        for (int i = 0; i < (1 << CW) - 1; i++) push_pkt(0, 1);
        drain(1200);
        chk("cnt_all_ones", pkt_cnt[CW-1:0], (1 << CW) - 1);
        push_pkt(0, 1);
        drain(20);
        chk("cnt_wrap", pkt_cnt[CW-1:0], 0);

        // Asynchronous reset during beat 2 of a 4-beat packet
        do_reset();
        push_pkt(0, 4);
        for (int c = 0; c < 3; c++) step(2'b01, 1'b1);
        @(posedge clock);
        #2;
        chk("pre_reset_mvalid", m_if.tvalid, 1);
        reset = 1'b1;
        #1;
        chk("rst_grant", grant, '0);
        chk("rst_s_tready", s_if.tready, '0);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_pkt_cnt", pkt_cnt, '0);
        clear_inputs();
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        push_pkt(1, 1);
        push_pkt(0, 1);
        step(2'b11, 1'b1);
        step(2'b11, 1'b1);
        chk("post_reset_grant", grant, 2'b01);
        drain(20);

        // Randomized traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 2500; cyc++) begin
            logic [NP-1:0] en;
            for (int p = 0; p < NP; p++) begin
                if (src_tail[p] - src_head[p] < 6 && $urandom_range(0, 3) == 0)
                    push_pkt(p, int'($urandom_range(1, 4)));
                en[p] = ($urandom_range(0, 3) != 0);
            end
            step(en, $urandom_range(0, 9) < 7);
        end
        drain(300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ipsa_ingress_arbiter.md
# ipsa_ingress_arbiter

Packet-granular round-robin arbiter that shares the single 1024-bit IPSA ingress path between several upstream AXI4-Stream sources, e.g. the CMAC width converter and a host/PCIe injection stream. It sits between the source-side 1024-bit streams and the InAXI adapter. Once a port is granted, it owns the path until its `tlast` beat is accepted, so packets are never interleaved. The block drives the downstream stream from a registered output slice and keeps per-port packet counters for debug.

## Interface
- `NUM_PORTS`, 2, number of requesting stream ports (2..4)
- `DATA_W`, 1024, tdata width in bits
- `KEEP_W`, DATA_W/8, tkeep width
- `CNT_W`, 32, width of each per-port packet counter
- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `s_axis_tvalid` in NUM_PORTS: per-port valid.
- `s_axis_tready` out NUM_PORTS: per-port ready.
- `s_axis_tdata` in NUM_PORTS*DATA_W: port p occupies bits [p*DATA_W +: DATA_W].
- `s_axis_tkeep` in NUM_PORTS*KEEP_W: same packing as tdata.
- `s_axis_tlast` in NUM_PORTS: per-port last.
- `m_axis_tvalid` out 1: downstream valid (registered).
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tdata` out DATA_W: registered data.
- `m_axis_tkeep` out KEEP_W: registered keep.
- `m_axis_tlast` out 1: registered last.
- `grant` out NUM_PORTS: one-hot owner of the path; all-zero when idle.
- `pkt_cnt` out NUM_PORTS*CNT_W: packets forwarded per port, same packing as tdata.

## Operation
- Reset state:
  - state IDLE, `rr_ptr`=0, `grant`=0, all `s_axis_tready`=0.
  - `m_axis_tvalid`/`tlast`=0, `m_axis_tdata`/`tkeep`=0, all `pkt_cnt`=0.
- FSM, two states:
  - IDLE: scan ports `rr_ptr`, `rr_ptr+1`, … mod NUM_PORTS. The first port with `s_axis_tvalid`=1 becomes `g`. Next cycle: state BUSY and `grant`=onehot(g). If no port is valid, stay in IDLE.
  - BUSY: `s_axis_tready[g]` = `slice_ready`; all other readies are 0. An accepted beat (valid&ready) is loaded into the output slice.
  - On an accepted beat with `tlast`=1: `pkt_cnt[g]`++; `rr_ptr` ← (g+1) mod NUM_PORTS; state IDLE and `grant`=0 next cycle.
- Output slice: one register stage, `slice_ready` = !`m_axis_tvalid` | `m_axis_tready`.
  - A load sets `m_axis_tvalid`=1 and captures data/keep/last unchanged.
  - `m_axis_tvalid` clears when `m_axis_tready`=1 and no load happens that cycle.
- No readiness is granted in IDLE. `s_axis_tready` never depends combinationally on `s_axis_tvalid`.
- Data, keep and last pass through bit-exact; no reordering, no drops.
- Counters wrap from 2^CNT_W−1 to 0.

## Timing
- Arbitration latency: the first beat is accepted no earlier than 1 cycle after `tvalid` is seen in IDLE. It appears on `m_axis` on the cycle after acceptance, 2 cycles after request.
- Within a packet, throughput is 1 beat/cycle while `m_axis_tready`=1.
- Between back-to-back packets there is exactly 1 idle cycle (the IDLE arbitration cycle), plus the slice drain if the downstream stalls.
- Source `tvalid` deasserting mid-packet: stay in BUSY holding the grant indefinitely; no timeout.
- Downstream stall: the slice holds its contents stable; `s_axis_tready[g]`=0 while the slice is full and `m_axis_tready`=0.
- Single-beat packet (`tlast` on the first beat): 1 beat transferred, return to IDLE, counter +1.
- Simultaneous requests: the port nearest `rr_ptr` in rotation wins; the losers keep `tvalid` asserted and wait.
- A request arriving on another port during BUSY is ignored until the next IDLE.
- Reset asserted mid-packet:
  - Immediately: `grant`=0, readies 0, `m_axis_tvalid`=0.
  - The partial packet is discarded; the sources are responsible for re-framing.

## Test plan
- Single port 0, 3-beat packet, `m_axis_tready`=1 → `grant`=01 from cycle 1; beats appear on `m_axis` in cycles 2,3,4 with `tlast` on the 3rd; `pkt_cnt[0]`=1; `grant`=00 after.
- Ports 0 and 1 both assert 2-beat packets at cycle 0 after reset → port 0 is forwarded first, then after 1 idle cycle port 1; `rr_ptr`=0 at the next contention; each counter=1; no interleaved beats.
- Port 1 packet with `m_axis_tready` toggling 1,0,0,1,… → output beats stay stable while stalled, all 4 beats are delivered in order, and port 1 `tready` is 0 whenever the slice is full and stalled.
- Port 0 drops `tvalid` for 5 cycles mid-packet while port 1 requests → port 1 gets no ready; port 0 completes, then port 1 is granted.
- Preload `pkt_cnt[0]` to 0xFFFFFFFF via 2^32−1 forced packets (or force) and send 1 more single-beat packet → `pkt_cnt[0]`=0.
- Assert `reset` during beat 2 of a 4-beat packet → all outputs 0 within the same cycle; after release the next packet is arbitrated from `rr_ptr`=0.
